// File: rtl/button_debounce_repeat_if.sv
// Signal bundle between the board pushbuttons / input logic and the
// debounce front end. The master side drives buttons and enable.
interface button_debounce_repeat_if #(
  parameter int NUM_BTNS = 3
);
  logic [NUM_BTNS-1:0] btn_n;
  logic                enable;
  logic [NUM_BTNS-1:0] press_pulse;
  logic [NUM_BTNS-1:0] release_pulse;
  logic [NUM_BTNS-1:0] held;
  logic                any_pulse;

  modport master (
    output btn_n,
    output enable,
    input  press_pulse,
    input  release_pulse,
    input  held,
    input  any_pulse
  );

  modport slave (
    input  btn_n,
    input  enable,
    output press_pulse,
    output release_pulse,
    output held,
    output any_pulse
  );
endinterface

// File: rtl/button_debounce_repeat.sv
// Per-button synchroniser, debouncer and press/repeat/release pulse generator
// feeding the game's digit-entry and control FSMs.
module button_debounce_repeat #(
  parameter int NUM_BTNS        = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  button_debounce_repeat_if.slave bus
);

  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DW-1:0] DLAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RLAST_DLY = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RLAST_PER = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_RELEASED,
    S_DB_PRESS,
    S_PRESSED,
    S_DB_RELEASE
  } state_t;

  logic [NUM_BTNS-1:0] sync1_q;
  logic [NUM_BTNS-1:0] sync2_q;
  logic [NUM_BTNS-1:0] press_vec;
  logic [NUM_BTNS-1:0] release_vec;
  logic [NUM_BTNS-1:0] held_vec;

  // Two-flop synchroniser; resets to the released (high) level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= bus.btn_n;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    state_t        state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          first_q, first_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          held_q, held_d;
    logic          pressed_s;
    logic          press_ev;
    logic          rel_ev;
    logic [RW-1:0] rlimit;

    assign pressed_s = ~sync2_q[g];
    assign rlimit    = first_q ? RLAST_DLY : RLAST_PER;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= S_RELEASED;
        dcnt_q  <= '0;
        rcnt_q  <= '0;
        first_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        held_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        dcnt_q  <= dcnt_d;
        rcnt_q  <= rcnt_d;
        first_q <= first_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        held_q  <= held_d;
      end
    end

    always_comb begin
      state_d  = state_q;
      dcnt_d   = dcnt_q;
      rcnt_d   = rcnt_q;
      first_d  = first_q;
      press_ev = 1'b0;
      rel_ev   = 1'b0;

      unique case (state_q)
        S_RELEASED: begin
          if (pressed_s) begin
            state_d = S_DB_PRESS;
            dcnt_d  = '0;
          end
        end

        S_DB_PRESS: begin
          if (!pressed_s) begin
            state_d = S_RELEASED;
            dcnt_d  = '0;
          end else if (dcnt_q == DLAST) begin
            state_d  = S_PRESSED;
            dcnt_d   = '0;
            rcnt_d   = '0;
            first_d  = 1'b1;
            press_ev = 1'b1;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end

        S_PRESSED: begin
          // Release detection wins over a repeat falling due on the same edge.
          if (!pressed_s) begin
            state_d = S_DB_RELEASE;
            dcnt_d  = '0;
          end else if (REPEAT_EN) begin
            if (rcnt_q == rlimit) begin
              press_ev = 1'b1;
              rcnt_d   = '0;
              first_d  = 1'b0;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
        end

        S_DB_RELEASE: begin
          // Repeat count is frozen here so a rejected release glitch resumes it.
          if (pressed_s) begin
            state_d = S_PRESSED;
            dcnt_d  = '0;
          end else if (dcnt_q == DLAST) begin
            state_d = S_RELEASED;
            dcnt_d  = '0;
            rel_ev  = 1'b1;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end

        default: begin
          state_d = S_RELEASED;
          dcnt_d  = '0;
          rcnt_d  = '0;
          first_d = 1'b0;
        end
      endcase
    end

    assign press_d = press_ev & bus.enable;
    assign rel_d   = rel_ev & bus.enable;
    assign held_d  = (state_d == S_PRESSED) || (state_d == S_DB_RELEASE);

    assign press_vec[g]   = press_q;
    assign release_vec[g] = rel_q;
    assign held_vec[g]    = held_q;
  end

  assign bus.press_pulse   = press_vec;
  assign bus.release_pulse = release_vec;
  assign bus.held          = held_vec;
  assign bus.any_pulse     = |press_vec;

endmodule

// File: doc/button_debounce_repeat.md
Name: button_debounce_repeat

Overview:
- Pushbutton front end that generates the one-cycle digit/confirm pulses consumed by the game's input control logic.
- Per button: synchronises the raw active-low button, debounces it, and emits a single-cycle press pulse.
- Optionally emits auto-repeat pulses while the button is held, and a release pulse on debounced release.
- Sits between the board pushbuttons and the digit-entry / FSM logic.

Parameters:
- NUM_BTNS, 3, number of independent buttons.
- DEBOUNCE_CYCLES, 500000, stable cycles required to accept a press or release (10 ms at 50 MHz); must be >= 2.
- REPEAT_DELAY, 25000000, cycles from the press pulse to the first repeat pulse.
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses.
- REPEAT_EN, 1, 1 enables auto-repeat; 0 gives one pulse per press.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- btn_n  in  NUM_BTNS  raw pushbuttons; 0 = pressed. Asynchronous to clk.
- enable  in  1  1 = pulses allowed; 0 = press_pulse and release_pulse forced low. The FSMs keep running.
- press_pulse  out  NUM_BTNS  one-cycle pulse on an accepted press and on each repeat.
- release_pulse  out  NUM_BTNS  one-cycle pulse on an accepted release.
- held  out  NUM_BTNS  level; debounced pressed state.
- any_pulse  out  1  OR of all press_pulse bits.

Behaviour:
- Reset (rst=0), applied immediately and asynchronously:
  - Both synchroniser flops per button load 1 (released).
  - All FSMs go to RELEASED; all counters go to 0.
  - All outputs go to 0.
- Synchroniser: two flops per button. pressed_s = ~second flop.
- Edge naming: E0 is the first clk edge whose first flop samples the new raw level.
- Per-button FSM states: RELEASED, DB_PRESS, PRESSED, DB_RELEASE.
- RELEASED:
  - pressed_s=1 → DB_PRESS with dcnt=0. This transition occurs at E0+2.
- DB_PRESS:
  - pressed_s=0 → RELEASED (bounce rejected, no pulse).
  - Otherwise dcnt increments.
  - When dcnt==DEBOUNCE_CYCLES-1 → PRESSED, with rcnt=0 and first_rep=1.
- PRESSED entry: press_pulse is registered high for exactly the cycle following the entry edge, which is edge E0+DEBOUNCE_CYCLES+2.
- PRESSED:
  - pressed_s=0 → DB_RELEASE with dcnt=0.
  - If REPEAT_EN=1, rcnt increments each cycle.
  - Repeat pulse is issued when rcnt reaches (first_rep ? REPEAT_DELAY : REPEAT_PERIOD)-1. At that point rcnt clears and first_rep clears.
  - Net effect: repeat pulses appear REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles.
- DB_RELEASE:
  - pressed_s=1 → back to PRESSED, no pulse; rcnt and first_rep are kept.
  - Otherwise dcnt increments.
  - When dcnt==DEBOUNCE_CYCLES-1 → RELEASED; release_pulse is high for the next cycle.
  - Repeat pulses are suppressed while in DB_RELEASE.
- held=1 in PRESSED and DB_RELEASE; registered with the same timing as the state.
- Buttons are fully independent. Simultaneous presses produce simultaneous pulses; there is no priority or arbitration.
- enable=0 masks pulses at the output register. A press accepted while enable=0 is lost, not deferred.
- Pulse width: never more than one cycle per event; a pulse never appears in two consecutive cycles.
- Counter widths are $clog2 of the relevant maximum parameter. Counters saturate-free by construction because they are cleared on every state transition.
- Reset mid-hold: after rst deasserts with the button still held, a new press is accepted with the standard latency measured from the first edge after reset.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, NUM_BTNS=3):
1. Assert rst=0 for 3 cycles with btn_n=3'b000 → all outputs 0 during reset. After release, btn0 press_pulse appears in the cycle after edge 6 (counting from the first post-reset edge) and held=3'b111.
2. REPEAT_EN=0; btn_n[0] low for 20 cycles, then high → single press_pulse[0] after edge E0+6; held[0] high from then; release_pulse[0] and held[0] low after edge E0'+6 of the release.
3. btn_n[1] bounce pattern 0,0,1,0,0,1,0 then held low → no pulse during the bounce; press_pulse[1] exactly 6 edges after the final falling sample.
4. REPEAT_EN=1; btn_n[2] held 30 cycles → press_pulse[2] at relative cycles 6, 16, 19, 22, 25, 28, 31 (relative to E0); any_pulse mirrors these. No repeat once in DB_RELEASE.
5. enable=0 during a full press/release of btn0 → press_pulse and release_pulse stay 0 while held toggles normally. Raising enable mid-hold with REPEAT_EN=1 → the next scheduled repeat pulse does appear.
6. Release glitch: in PRESSED, btn high for 2 cycles then low again → no release_pulse, held stays 1, no extra press_pulse.
